// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Round-robin
// arbitration picks one valid request per cycle. The granted operands are
// muxed onto the ALU in the same cycle. The ALU result, including its carry
// bit, is registered into a one-entry response slot for the winning port.
// Control codes the ALU does not support are not forwarded to the ALU. They
// return an error response with a zero result instead.
//
// Ports
//   clk, reset_b            rising-edge clock, async active-low reset
//   reqN_valid/ready        request handshake, requester N (N = 0, 1)
//   reqN_in1/in2/ctrl       operands and ALU control code
//   rspN_valid/ready        response handshake, requester N
//   rspN_result/err         captured ALU result / unsupported-code flag
//   alu_in1/in2/control     drive to the shared ALU
//   alu_result              combinational result from the shared ALU
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int REG_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset_b,

   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [REG_WIDTH-1:0] req0_in1,
   input  logic [REG_WIDTH-1:0] req0_in2,
   input  logic [3:0]           req0_ctrl,
   output logic                 rsp0_valid,
   input  logic                 rsp0_ready,
   output logic [REG_WIDTH:0]   rsp0_result,
   output logic                 rsp0_err,

   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [REG_WIDTH-1:0] req1_in1,
   input  logic [REG_WIDTH-1:0] req1_in2,
   input  logic [3:0]           req1_ctrl,
   output logic                 rsp1_valid,
   input  logic                 rsp1_ready,
   output logic [REG_WIDTH:0]   rsp1_result,
   output logic                 rsp1_err,

   output logic [REG_WIDTH-1:0] alu_in1,
   output logic [REG_WIDTH-1:0] alu_in2,
   output logic [3:0]           alu_control,
   input  logic [REG_WIDTH:0]   alu_result
);

   function automatic logic ctrl_supported(input logic [3:0] code);
      logic ok;
      case (code)
         4'b0000, 4'b0001, 4'b0010, 4'b0011,
         4'b0110, 4'b0111, 4'b1000, 4'b1001: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   logic elig0, elig1;
   logic grant0, grant1;
   logic last;          // port that won the most recent grant
   logic sup0, sup1;

   assign sup0 = ctrl_supported(req0_ctrl);
   assign sup1 = ctrl_supported(req1_ctrl);

   // A port may issue when its slot is empty or drains in this same cycle.
   // Grants are forced low while reset is asserted. This is needed because
   // the slots read as empty during reset and would otherwise let a request
   // through.
   always_comb begin
      elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
      elig1 = req1_valid & (~rsp1_valid | rsp1_ready);
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset_b) begin
         if (elig0 && elig1) begin
            grant0 = last;
            grant1 = ~last;
         end else begin
            grant0 = elig0;
            grant1 = elig1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // The ALU sees all-zero inputs when idle or for an unsupported code.
   // This keeps illegal codes away from the ALU.
   always_comb begin
      alu_in1     = '0;
      alu_in2     = '0;
      alu_control = 4'b0000;
      if (grant0) begin
         alu_in1     = req0_in1;
         alu_in2     = req0_in2;
         alu_control = sup0 ? req0_ctrl : 4'b0000;
      end else if (grant1) begin
         alu_in1     = req1_in1;
         alu_in2     = req1_in2;
         alu_control = sup1 ? req1_ctrl : 4'b0000;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         last <= 1'b1;
      end else if (grant0) begin
         last <= 1'b0;
      end else if (grant1) begin
         last <= 1'b1;
      end
   end

   // Response slot 0. An accept that arrives while the slot drains
   // overwrites the slot, so rsp0_valid stays high for back-to-back results.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp0_err    <= 1'b0;
      end else if (grant0) begin
         rsp0_valid  <= 1'b1;
         rsp0_result <= sup0 ? alu_result : '0;
         rsp0_err    <= ~sup0;
      end else if (rsp0_valid && rsp0_ready) begin
         rsp0_valid  <= 1'b0;
      end
   end

   // Response slot 1
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
         rsp1_err    <= 1'b0;
      end else if (grant1) begin
         rsp1_valid  <= 1'b1;
         rsp1_result <= sup1 ? alu_result : '0;
         rsp1_err    <= ~sup1;
      end else if (rsp1_valid && rsp1_ready) begin
         rsp1_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Testbench for alu_arbiter. It models the shared ALU itself, runs directed
// and random traffic, and keeps a reference model of slot occupancy and
// arbitration. Expected responses are queued per port when a request is
// accepted. A monitor pops the queues and compares them against the
// responses the DUT presents.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset_b;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]  req0_in1, req0_in2, req1_in1, req1_in2;
   logic [3:0]    req0_ctrl, req1_ctrl;
   logic          rsp0_valid, rsp0_ready, rsp0_err;
   logic          rsp1_valid, rsp1_ready, rsp1_err;
   logic [W:0]    rsp0_result, rsp1_result;
   logic [W-1:0]  alu_in1, alu_in2;
   logic [3:0]    alu_control;
   logic [W:0]    alu_result;

   int n_tests = 0;
   int n_fail  = 0;

   // {err, result} expected for each port, in order of acceptance
   logic [W+1:0]  q0[$];
   logic [W+1:0]  q1[$];
   logic          full_m0, full_m1, last_m;

   always #5 clk = ~clk;

   alu_arbiter #(.REG_WIDTH(W)) dut (
      .clk(clk), .reset_b(reset_b),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
      .alu_result(alu_result)
   );

   function automatic logic sup_ref(input logic [3:0] c);
      return c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9};
   endfunction

   // Behavioural ALU. The top bit is the carry/borrow for ADD/SUB, the bit
   // shifted out for SLL, and 0 for the other codes.
   function automatic logic [W:0] alu_ref(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [3:0]   c);
      logic [W:0] r;
      case (c)
         4'd0:    r = {1'b0, a & b};
         4'd1:    r = {1'b0, a | b};
         4'd2:    r = {1'b0, a} + {1'b0, b};
         4'd3:    r = {1'b0, a ^ b};
         4'd6:    r = {1'b0, a} - {1'b0, b};
         4'd7:    r = {1'b0, a} << b[4:0];
         4'd8:    r = {1'b0, a >> b[4:0]};
         4'd9:    r = {1'b0, $unsigned($signed(a) >>> b[4:0])};
         default: r = '0;
      endcase
      return r;
   endfunction

   always_comb alu_result = alu_ref(alu_in1, alu_in2, alu_control);

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W+1:0] expect_rsp(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic [3:0]   c);
      if (sup_ref(c)) return {1'b0, alu_ref(a, b, c)};
      return {1'b1, {(W+1){1'b0}}};
   endfunction

   // Reference model: slot occupancy, round-robin winner, ALU drive. It
   // pushes expected responses when it predicts an accept.
   always @(negedge clk) begin
      logic e0, e1, g0, g1;
      logic [3:0] ectrl;
      if (!reset_b) begin
         q0.delete();
         q1.delete();
         full_m0 = 1'b0;
         full_m1 = 1'b0;
         last_m  = 1'b1;
         chk("reset_ready", {req0_ready, req1_ready}, 2'b00);
         chk("reset_alu_idle", {alu_in1, alu_in2, alu_control}, '0);
      end else begin
         e0 = req0_valid && (!full_m0 || rsp0_ready);
         e1 = req1_valid && (!full_m1 || rsp1_ready);
         if (e0 && e1) begin
            g0 = (last_m == 1'b1);
            g1 = !g0;
         end else begin
            g0 = e0;
            g1 = e1;
         end
         chk("grant", {req1_ready, req0_ready}, {g1, g0});
         chk("rsp_valid", {rsp1_valid, rsp0_valid}, {full_m1, full_m0});
         if (g0) begin
            ectrl = sup_ref(req0_ctrl) ? req0_ctrl : 4'd0;
            chk("alu_drive0", {alu_in1, alu_in2, alu_control},
                {req0_in1, req0_in2, ectrl});
         end else if (g1) begin
            ectrl = sup_ref(req1_ctrl) ? req1_ctrl : 4'd0;
            chk("alu_drive1", {alu_in1, alu_in2, alu_control},
                {req1_in1, req1_in2, ectrl});
         end else begin
            chk("alu_idle", {alu_in1, alu_in2, alu_control}, '0);
         end
         if (g0) begin
            q0.push_back(expect_rsp(req0_in1, req0_in2, req0_ctrl));
            full_m0 = 1'b1;
            last_m  = 1'b0;
         end else if (full_m0 && rsp0_ready) begin
            full_m0 = 1'b0;
         end
         if (g1) begin
            q1.push_back(expect_rsp(req1_in1, req1_in2, req1_ctrl));
            full_m1 = 1'b1;
            last_m  = 1'b1;
         end else if (full_m1 && rsp1_ready) begin
            full_m1 = 1'b0;
         end
      end
   end

   // Monitor: compares each presented response with the head of its queue
   // every cycle, and pops the entry when the response is consumed.
   always @(negedge clk) begin
      if (reset_b) begin
         if (rsp0_valid) begin
            if (q0.size() == 0) begin
               chk("rsp0_unexpected", 1'b1, 1'b0);
            end else begin
               chk("rsp0_data", {rsp0_err, rsp0_result}, q0[0]);
               if (rsp0_ready) void'(q0.pop_front());
            end
         end
         if (rsp1_valid) begin
            if (q1.size() == 0) begin
               chk("rsp1_unexpected", 1'b1, 1'b0);
            end else begin
               chk("rsp1_data", {rsp1_err, rsp1_result}, q1[0]);
               if (rsp1_ready) void'(q1.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_b    = 1'b0;
      req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_ctrl = 4'd0;
      req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_ctrl = 4'd0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;

      // ADD with carry. The request is held during reset and must be
      // accepted in the first cycle after release.
      req0_valid = 1'b1; req0_in1 = 32'hFFFF_FFFF; req0_in2 = 32'h1;
      req0_ctrl  = 4'b0010;
      repeat (3) step();
      chk("reset_rsp0", {rsp0_valid, rsp0_err, rsp0_result}, '0);
      reset_b = 1'b1;
      @(negedge clk);
      chk("first_accept", req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("add_carry", {rsp0_valid, rsp0_err, rsp0_result},
          {1'b1, 1'b0, 33'h1_0000_0000});

      // Alternation from reset: both ports valid, grants 0,1,0,1
      step();
      reset_b = 1'b0;
      step();
      reset_b = 1'b1;
      req0_valid = 1'b1; req0_in1 = 32'hF0F0_F0F0; req0_in2 = 32'hFF00_FF00;
      req0_ctrl  = 4'b0000;
      req1_valid = 1'b1; req1_in1 = 32'd5; req1_in2 = 32'd3;
      req1_ctrl  = 4'b0110;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("alternate", {req0_ready, req1_ready},
             {(i % 2) == 0, (i % 2) == 1});
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk("and_result", rsp0_result, 33'h0_F000_F000);
      chk("sub_result", rsp1_result, 33'h0_0000_0002);

      // Stall port 1 after an SRA while port 0 keeps issuing XORs
      step();
      rsp1_ready = 1'b0;
      req1_valid = 1'b1; req1_in1 = 32'h8000_0000; req1_in2 = 32'd4;
      req1_ctrl  = 4'b1001;
      @(negedge clk);
      chk("sra_accept", req1_ready, 1'b1);
      step();
      req0_valid = 1'b1; req0_ctrl = 4'b0011;
      req0_in1 = $urandom; req0_in2 = $urandom;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_no_grant1", {req1_ready, req0_ready}, 2'b01);
         chk("stall_hold", {rsp1_valid, rsp1_result}, {1'b1, 33'h0_F800_0000});
         step();
         req0_in1 = $urandom; req0_in2 = $urandom;
      end
      rsp1_ready = 1'b1;
      @(negedge clk);
      chk("drain_regrant", {req1_ready, req0_ready}, 2'b10);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Unsupported control code
      step();
      req0_valid = 1'b1; req0_ctrl = 4'b0101;
      req0_in1 = $urandom; req0_in2 = $urandom;
      @(negedge clk);
      chk("bad_ctrl_accept", {req0_ready, alu_control}, {1'b1, 4'b0000});
      step();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("bad_ctrl_rsp", {rsp0_valid, rsp0_err, rsp0_result},
          {1'b1, 1'b1, 33'h0});

      // SLL accepted, then reset before the response is consumed
      step();
      req0_valid = 1'b1; req0_in1 = 32'd1; req0_in2 = 32'd3; req0_ctrl = 4'b0111;
      step();
      req0_valid = 1'b0; rsp0_ready = 1'b0;
      @(negedge clk);
      chk("sll_result", {rsp0_valid, rsp0_result}, {1'b1, 33'h8});
      #2 reset_b = 1'b0;
      #1 chk("reset_discard", {rsp0_valid, rsp0_err, rsp0_result}, '0);
      req0_valid = 1'b1; req0_ctrl = 4'b0000; req0_in1 = $urandom;
      req1_valid = 1'b1; req1_ctrl = 4'b0001; req1_in1 = $urandom;
      rsp0_ready = 1'b1;
      step();
      step();
      reset_b = 1'b1;
      @(negedge clk);
      chk("post_reset_prio", {req0_ready, req1_ready}, 2'b10);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Random traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         step();
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_in1 = $urandom; req0_in2 = $urandom;
         req1_in1 = $urandom; req1_in2 = $urandom;
         req0_ctrl = 4'($urandom_range(0, 15));
         req1_ctrl = 4'($urandom_range(0, 15));
         rsp0_ready = ($urandom_range(0, 3) != 0);
         rsp1_ready = ($urandom_range(0, 3) != 0);
      end

      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("queues_drained", {32'(q0.size()), 32'(q1.size())}, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between two requesters, for example the execute stage (port 0) and a branch/address-compute unit (port 1). It uses valid/ready handshakes and round-robin arbitration. The block drives the shared ALU's operand and control inputs from the granted request in the same cycle, then registers the (REG_WIDTH+1)-bit result, including the carry bit, into a per-requester response buffer. It also screens out unsupported `alu_control` codes and flags them as errors instead of passing them to the ALU.

## Interface
- `REG_WIDTH`, default 32: operand width; results are REG_WIDTH+1 bits.
- `clk` in 1: single clock, rising edge.
- `reset_b` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N = 0, 1): requester N presents an operation.
- `reqN_ready` out 1: operation from requester N is accepted this cycle.
- `reqN_in1`, `reqN_in2` in REG_WIDTH: operands.
- `reqN_ctrl` in 4: ALU control code.
- `rspN_valid` out 1: response buffered for requester N.
- `rspN_ready` in 1: requester N consumes the response.
- `rspN_result` out REG_WIDTH+1: captured ALU result.
- `rspN_err` out 1: the operation used an unsupported control code.
- `alu_in1`, `alu_in2` out REG_WIDTH: to the shared ALU.
- `alu_control` out 4: to the shared ALU.
- `alu_result` in REG_WIDTH+1: from the shared ALU (combinational).

## Operation
- Supported codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
  - 0110 SUB, 0111 SLL, 1000 SRL, 1001 SRA.
  - All other codes are unsupported.
- Eligibility: eligN = reqN_valid & (~rspN_valid | rspN_ready). A requester may only issue when its response slot is empty or is draining this cycle.
- Round-robin grant, using a 1-bit register `last`:
  - Both eligible: grant requester ~last.
  - One eligible: grant it.
  - Neither eligible: no grant.
- reqN_ready = grantN. At most one reqN_ready is high per cycle. Requesters must not make reqN_valid depend on reqN_ready.
- ALU drive while a grant is active (combinational mux of the granted request):
  - alu_in1/alu_in2 take the granted operands.
  - alu_control takes the granted code if supported, otherwise 0000.
- ALU drive with no grant: alu_in1 = 0, alu_in2 = 0, alu_control = 0000.
- Capture at the rising edge for an accepted operation on port N:
  - Supported code: rspN_result <= alu_result, rspN_err <= 0.
  - Unsupported code: rspN_result <= 0, rspN_err <= 1.
  - In both cases rspN_valid <= 1 and last <= N.
- Drain: if rspN_valid & rspN_ready and there is no new accept on N, then rspN_valid <= 0. rspN_result and rspN_err keep their last value.
- Simultaneous drain and accept on the same port: the slot is overwritten with the new result and rspN_valid stays 1. This is back-to-back throughput.
- Stall: while rspN_valid & ~rspN_ready, rspN_result and rspN_err are held stable and port N is not granted. The other port continues to be served.
- Bit REG_WIDTH of the result is passed through unmodified from the ALU. The arbiter performs no arithmetic.
- The request is not retained after acceptance. The requester may change its operands the cycle after reqN_ready.

## Timing
- Reset (reset_b low, asynchronous):
  - Registered outputs: rspN_valid = 0, rspN_result = 0, rspN_err = 0, last = 1, so port 0 wins the first contention.
  - Combinational outputs during reset: reqN_ready = 0, and the ALU drive is the idle value.
  - Reset mid-operation: an accepted but undelivered response is discarded and no response is produced.
- Latency: accept in cycle T gives rspN_valid = 1 in cycle T+1.
- Throughput:
  - Aggregate: 1 operation per cycle.
  - Single port: 1 per cycle when rspN_ready is held high and the other port is idle.
  - Both ports continuously eligible: strict alternation.
- reqN_ready is combinational from reqN_valid, rspN_valid, rspN_ready and last.
- rspN_* outputs are driven only from registers.
- Release from reset: the first accept can happen in the first cycle with reset_b high.

## Test plan
- Reset, then req0 ADD with in1 = 0xFFFFFFFF, in2 = 0x1: accepted in cycle T; in T+1, rsp0_valid = 1 and rsp0_result = 0x1_00000000 (carry bit set), rsp0_err = 0.
- Both ports hold valid continuously (req0 AND 0xF0F0F0F0 & 0xFF00FF00, req1 SUB 5 − 3), with rsp_ready held high:
  - Grants go 0, 1, 0, 1.
  - rsp0_result = 0x0_F000F000 and rsp1_result = 0x0_00000002.
  - reqN_ready is never high on both ports in the same cycle.
- rsp1_ready held low after a req1 SRA (0x80000000 >>> 4): rsp1_result stays 0x0_F8000000 and req1 gets no grant; req0 XOR requests still complete every cycle. Raise rsp1_ready: the slot drains and req1 is granted again in the same cycle.
- req0 with ctrl 4'b0101: accepted; alu_control = 0000 that cycle; next cycle rsp0_err = 1 and rsp0_result = 0.
- req0 SLL (1 << 3) accepted, then reset_b pulsed low before rsp0_ready: after reset, rsp0_valid = 0 and rsp0_result = 0. The next contention with both ports valid grants port 0.
